// File: rtl/serial_cmp_if.sv
// serial_cmp_if: request/result handshake bundle for serial_cmp_unit
interface serial_cmp_if #(parameter int WIDTH = 16);
    logic             start_valid;
    logic             start_ready;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             busy;
    modport master (output start_valid, mode, a, b, res_ready,
                    input start_ready, res_valid, result, busy);
    modport slave (input start_valid, mode, a, b, res_ready,
                   output start_ready, res_valid, result, busy);
endinterface

// File: rtl/serial_cmp_unit.sv
// serial_cmp_unit: digit-serial MSB-first set-on-compare (SLT/SLTU/SEQ/SNE) with early exit
module serial_cmp_unit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic        clk,
    input logic        rst,
    serial_cmp_if.slave io
);
    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, nxt;
    logic [WIDTH-1:0] ra, rb;
    logic [1:0] rm;
    logic [KW-1:0] k;
    logic flag;
    logic [DIGIT-1:0] ca, cb;
    logic diff, last, slt;
    // operands shift left each RUN cycle, so the current chunk is always the top digit
    assign ca = ra[WIDTH-1 -: DIGIT];
    assign cb = rb[WIDTH-1 -: DIGIT];
    assign diff = ca != cb;
    assign last = k == KW'(NCHUNK - 1);
    assign slt = io.mode == 2'b00;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        nxt = state == IDLE ? (io.start_valid ? RUN : IDLE)
            : state == RUN  ? (diff || last ? DONE : RUN)
            : (io.res_ready ? IDLE : DONE);
    end
    // flipping the sign bits maps signed order onto unsigned order
    always_ff @(posedge clk) begin
        if (rst) begin
            ra <= '0;
            rb <= '0;
            rm <= '0;
            k <= '0;
            flag <= 1'b0;
        end else if (state == IDLE && io.start_valid) begin
            ra <= {io.a[WIDTH-1] ^ slt, io.a[WIDTH-2:0]};
            rb <= {io.b[WIDTH-1] ^ slt, io.b[WIDTH-2:0]};
            rm <= io.mode;
            k <= '0;
            flag <= 1'b0;
        end else if (state == RUN) begin
            if (diff) flag <= rm[1] ? rm[0] : ca < cb;
            else if (last) flag <= rm == 2'b10;
            else begin
                k <= k + 1'b1;
                ra <= ra << DIGIT;
                rb <= rb << DIGIT;
            end
        end else if (state == DONE && io.res_ready) begin
            flag <= 1'b0;
            k <= '0;
        end
    end
    always_comb begin
        io.start_ready = state == IDLE;
        io.res_valid = state == DONE;
        io.busy = state != IDLE;
        io.result = {{(WIDTH-1){1'b0}}, flag};
    end
endmodule

// File: tb/tb_serial_cmp_unit.sv
// tb_serial_cmp_unit: directed and randomized checks of serial_cmp_unit against an arithmetic model
module tb_serial_cmp_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    serial_cmp_if #(.WIDTH(16)) bus();
    serial_cmp_unit #(.WIDTH(16), .DIGIT(4)) dut (.clk(clk), .rst(rst), .io(bus));
    always #5 clk = ~clk;

    function automatic logic exp_flag(logic [1:0] m, logic [15:0] x, logic [15:0] y);
        case (m)
            2'd0: return $signed(x) < $signed(y);
            2'd1: return x < y;
            2'd2: return x == y;
            default: return x != y;
        endcase
    endfunction

    // cycles from the accept edge (counted as 1) to the edge after which res_valid is seen
    function automatic int exp_lat(logic [15:0] x, logic [15:0] y);
        logic [15:0] d;
        d = x ^ y;
        for (int j = 0; j < 4; j++) if (d[15-4*j -: 4] != 4'h0) return 2 + j;
        return 5;
    endfunction

    task automatic do_op(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y,
                         output int lat, output logic [15:0] res);
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.mode = m;
        bus.a = x;
        bus.b = y;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.mode = 2'($urandom);
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        lat = -1;
        for (int c = 2; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) begin
                lat = c;
                break;
            end
        end
        res = bus.result;
    endtask

    task automatic consume();
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.result !== 16'h0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset: ready=%b valid=%b result=%h busy=%b want 1 0 0000 0",
                     bus.start_ready, bus.res_valid, bus.result, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0] tm [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd3};
        logic [15:0] ta [8] = '{16'h0004, 16'h0004, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h1234, 16'h1234, 16'h1234};
        logic [15:0] tb [8] = '{16'h0005, 16'h0001, 16'h0001, 16'h0001, 16'h7FFF, 16'h1234, 16'h1234, 16'h1235};
        logic tr [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int tl [8] = '{5, 5, 2, 2, 2, 5, 5, 5};
        int lat;
        logic [15:0] res;
        for (int i = 0; i < 8; i++) begin
            do_op(tm[i], ta[i], tb[i], lat, res);
            checks++;
            if (res !== {15'h0, tr[i]} || lat !== tl[i]) begin
                failures++;
                $display("FAIL directed[%0d]: result=%h lat=%0d want %h lat=%0d", i, res, lat, {15'h0, tr[i]}, tl[i]);
            end
            checks++;
            if (bus.start_ready !== 1'b0 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL directed_done[%0d]: ready=%b busy=%b want 0 1", i, bus.start_ready, bus.busy);
            end
            consume();
            checks++;
            if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.result !== 16'h0) begin
                failures++;
                $display("FAIL directed_idle[%0d]: ready=%b valid=%b result=%h want 1 0 0000",
                         i, bus.start_ready, bus.res_valid, bus.result);
            end
        end
    endtask

    task automatic test_random();
        int lat, c;
        logic [15:0] x, y, res;
        logic [1:0] m;
        for (int i = 0; i < 200; i++) begin
            m = 2'($urandom);
            x = 16'($urandom);
            c = $urandom_range(0, 5);
            y = c == 5 ? 16'($urandom) : c == 4 ? x : x ^ (16'($urandom_range(1, 15)) << (4 * c));
            do_op(m, x, y, lat, res);
            checks++;
            if (res !== {15'h0, exp_flag(m, x, y)} || lat !== exp_lat(x, y)) begin
                failures++;
                $display("FAIL random[%0d] m=%0d a=%h b=%h: result=%h lat=%0d want %h lat=%0d",
                         i, m, x, y, res, lat, {15'h0, exp_flag(m, x, y)}, exp_lat(x, y));
            end
            consume();
        end
    endtask

    task automatic test_stall();
        int lat;
        logic [15:0] res;
        do_op(2'd0, 16'h0004, 16'h0005, lat, res);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.start_valid = i == 1;
            bus.mode = 2'd2;
            bus.a = 16'h0;
            bus.b = 16'h0;
            @(posedge clk);
            #1;
            checks++;
            if (bus.res_valid !== 1'b1 || bus.result !== 16'h0001 || bus.start_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall[%0d]: valid=%b result=%h ready=%b want 1 0001 0",
                         i, bus.res_valid, bus.result, bus.start_ready);
            end
        end
        bus.start_valid = 1'b0;
        consume();
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
                failures++;
                $display("FAIL stall_ignored: busy=%b valid=%b ready=%b want 0 0 1",
                         bus.busy, bus.res_valid, bus.start_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [15:0] res;
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.mode = 2'd0;
        bus.a = 16'h0004;
        bus.b = 16'h0005;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.result !== 16'h0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: ready=%b valid=%b result=%h busy=%b want 1 0 0000 0",
                     bus.start_ready, bus.res_valid, bus.result, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(2'd0, 16'h0004, 16'h0005, lat, res);
        checks++;
        if (res !== 16'h0001 || lat !== 5) begin
            failures++;
            $display("FAIL reset_mid_after: result=%h lat=%0d want 0001 lat=5", res, lat);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [15:0] res;
        do_op(2'd3, 16'hABCD, 16'h1BCD, lat, res);
        @(negedge clk);
        bus.res_ready = 1'b1;
        bus.start_valid = 1'b1;
        bus.mode = 2'd2;
        bus.a = 16'h5A5A;
        bus.b = 16'h5A5A;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        checks++;
        if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_same_cycle: ready=%b busy=%b want 1 0", bus.start_ready, bus.busy);
        end
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        lat = -1;
        for (int c = 2; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (bus.result !== 16'h0001 || lat !== 5) begin
            failures++;
            $display("FAIL b2b_second: result=%h lat=%0d want 0001 lat=5", bus.result, lat);
        end
        consume();
    endtask

    initial begin
        bus.start_valid = 1'b0;
        bus.res_ready = 1'b0;
        bus.mode = 2'd0;
        bus.a = 16'h0;
        bus.b = 16'h0;
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
